coin_collector: RTL and testbench
=================================

# coin_collector

Consumes the coin-slot stream produced by the coin spawner and checks each active slot against the player's lane and a vertical hit window. Each coin is classified once as collected or missed. Collected slots get a clear request back to the spawner, and the block keeps the score and a consecutive-collect combo count for the HUD. It sits between the coin spawner/fall logic and the score display, in the 100 Hz game-tick domain.

## Interface
Parameters:
- HIT_Y_MIN, 9'd400, lowest coin y (inclusive) that can be collected
- HIT_Y_MAX, 9'd440, highest coin y (inclusive) that can be collected
- COIN_POINTS, 4'd1, base points per coin
- COMBO_BONUS_AT, 4'd5, combo value at or above which each coin scores 2×COIN_POINTS
- SCORE_MAX, 16'd9999, score saturation value

Ports:
- clk  in  1  game tick clock (100 Hz domain)
- rst  in  1  reset, asynchronous, active-low
- coins  in  6  three 2-bit slot lane codes (0 empty, 1..3 lane), slot0 = [1:0]
- y  in  27  three 9-bit slot y positions, slot0 = [8:0]
- player_lane  in  2  current player lane, 0 = airborne/none
- clear_req  out  3  per-slot request to the spawner to empty the slot
- collect  out  1  one-cycle pulse, at least one coin collected this cycle
- miss  out  1  one-cycle pulse, at least one coin missed this cycle
- score  out  16  saturating score
- combo  out  4  saturating consecutive-collect count

## Operation
- Each slot has an independent FSM: IDLE, ARMED, HIT, MISSED.
- IDLE → ARMED when the lane code is ≠0.
- ARMED → HIT when all of the following hold: the lane code equals player_lane, player_lane ≠0, and HIT_Y_MIN ≤ y ≤ HIT_Y_MAX.
- ARMED → MISSED when y > HIT_Y_MAX and the HIT condition is false.
- ARMED → IDLE when the lane code returns to 0 without a hit. No miss is counted.
- HIT holds clear_req[i]=1 until the lane code reads 0, then goes to IDLE. This is a level handshake: the spawner drops the slot and the block releases.
- MISSED waits for the lane code to read 0, then goes to IDLE. clear_req stays 0.
- A slot is classified exactly once per occupancy. Re-entering the window while in HIT or MISSED has no effect.
- hits = number of slots taking ARMED→HIT this cycle (0..3). misses = number of slots taking ARMED→MISSED this cycle.
- Points per hit are 2×COIN_POINTS if the pre-update combo ≥ COMBO_BONUS_AT, otherwise COIN_POINTS.
- score += hits×points, saturating at SCORE_MAX. Use a 17-bit intermediate and compare.
- combo update:
  - misses=0: combo = min(combo+hits, 15).
  - misses>0: combo = hits. The miss resets the combo first; collects in the same cycle then count.
- collect = (hits≠0). miss = (misses≠0).

## Timing
- The reset value of every output is 0. All FSMs reset to IDLE.
- Inputs are sampled on the rising edge of clk.
- One cycle of latency: a condition sampled at edge N produces the state change, clear_req, collect/miss pulses, score and combo at edge N.
- clear_req[i] is asserted from edge N until the first edge at which coins[2i+1:2i]==0 is sampled. It deasserts at that edge.
- If reset is asserted mid-handshake, clear_req drops immediately and the score is lost. The spawner must tolerate this.
- If a player_lane change and the window entry happen in the same cycle, the new player_lane is used.
- If y wraps past 511 to 0 while ARMED, the coin is already MISSED, because it passed HIT_Y_MAX first.

## Structure
- The shared package coin_pkg holds:
  - lane code constants (LANE_NONE=0, LANE_1..3)
  - the slot state enum (IDLE/ARMED/HIT/MISSED)
  - the slot field width (9) and the slot count (3)
- The sub-module coin_slot_tracker is instantiated three times. It contains one FSM and outputs clear_req, hit_evt and miss_evt.
- The top level holds the hit/miss counters, the score and combo registers, and saturation.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0. Release, then coins=0 for 10 cycles → no pulses.
- Single collect:
  - Stimulus: slot0 lane 2, player_lane=2, y ramps 0→420.
  - Response: collect pulses once when y=400 is sampled. score=1, combo=1, clear_req[0]=1.
  - Then drive coins[1:0]=0 → clear_req[0]=0 at the next edge.
- Miss:
  - Stimulus: slot1 lane 3, player_lane=1, y ramps to 441.
  - Response: miss pulse at y=441, combo resets to 0, clear_req[1] stays 0, score unchanged.
- Combo bonus: 5 sequential collects → score 5, combo 5. The 6th collect adds 2 → score 7, combo 6.
- Simultaneous:
  - Preload combo 3.
  - Same cycle: slot0 hit (lane 1, y=410), slot2 miss (y=441), player_lane=1.
  - Response: collect=1, miss=1, combo=1, score +1.
- Saturation: preload score 9998, then two simultaneous hits → score 9999. The next hit keeps 9999.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared definitions for the coin collector: lane codes, slot geometry and
// the per-slot classification state.
package coin_pkg;

    localparam int SLOT_W    = 9;
    localparam int NUM_SLOTS = 3;

    localparam logic [1:0] LANE_NONE = 2'd0;
    localparam logic [1:0] LANE_1    = 2'd1;
    localparam logic [1:0] LANE_2    = 2'd2;
    localparam logic [1:0] LANE_3    = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        HIT    = 2'd2,
        MISSED = 2'd3
    } slot_state_t;

    function automatic logic [1:0] count_ones3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/coin_slot_tracker.sv
// Classifies one coin slot per occupancy as hit or missed and holds the
// clear request towards the spawner while a collected coin is still present.
module coin_slot_tracker
    import coin_pkg::*;
#(
    parameter logic [SLOT_W-1:0] HIT_Y_MIN = 9'd400,
    parameter logic [SLOT_W-1:0] HIT_Y_MAX = 9'd440
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        lane,
    input  logic [SLOT_W-1:0] y,
    input  logic [1:0]        player_lane,
    output logic              clear_req,
    output logic              hit_evt,
    output logic              miss_evt
);

    slot_state_t state_reg;
    slot_state_t state_next;
    logic        hit_cond;

    assign hit_cond = (lane == player_lane) && (player_lane != LANE_NONE) &&
                      (y >= HIT_Y_MIN) && (y <= HIT_Y_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // hit_evt/miss_evt flag the transition taken at the coming edge so the
    // top can fold them into score and combo on that same edge.
    always_comb begin
        state_next = state_reg;
        hit_evt    = 1'b0;
        miss_evt   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (lane != LANE_NONE) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (lane == LANE_NONE) begin
                    state_next = IDLE;
                end else if (hit_cond) begin
                    state_next = HIT;
                    hit_evt    = 1'b1;
                end else if (y > HIT_Y_MAX) begin
                    state_next = MISSED;
                    miss_evt   = 1'b1;
                end
            end
            HIT, MISSED: begin
                if (lane == LANE_NONE) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign clear_req = (state_reg == HIT);

endmodule

// File: rtl/coin_collector.sv
// Per-slot coin classification feeding a saturating score and combo counter
// for the HUD, with clear requests back to the spawner.
module coin_collector
    import coin_pkg::*;
#(
    parameter logic [8:0]  HIT_Y_MIN      = 9'd400,
    parameter logic [8:0]  HIT_Y_MAX      = 9'd440,
    parameter logic [3:0]  COIN_POINTS    = 4'd1,
    parameter logic [3:0]  COMBO_BONUS_AT = 4'd5,
    parameter logic [15:0] SCORE_MAX      = 16'd9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  coins,
    input  logic [26:0] y,
    input  logic [1:0]  player_lane,
    output logic [2:0]  clear_req,
    output logic        collect,
    output logic        miss,
    output logic [15:0] score,
    output logic [3:0]  combo
);

    logic [NUM_SLOTS-1:0] hit_vec;
    logic [NUM_SLOTS-1:0] miss_vec;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            coin_slot_tracker #(
                .HIT_Y_MIN (HIT_Y_MIN),
                .HIT_Y_MAX (HIT_Y_MAX)
            ) u_tracker (
                .clk         (clk),
                .rst         (rst),
                .lane        (coins[2*gi +: 2]),
                .y           (y[SLOT_W*gi +: SLOT_W]),
                .player_lane (player_lane),
                .clear_req   (clear_req[gi]),
                .hit_evt     (hit_vec[gi]),
                .miss_evt    (miss_vec[gi])
            );
        end
    endgenerate

    logic [1:0]  hits;
    logic [1:0]  misses;
    logic [4:0]  points;
    logic [6:0]  add;
    logic [16:0] score_sum;
    logic [4:0]  combo_sum;
    logic [15:0] score_next;
    logic [3:0]  combo_next;
    logic [15:0] score_reg;
    logic [3:0]  combo_reg;
    logic        collect_reg;
    logic        miss_reg;

    assign hits   = count_ones3(hit_vec);
    assign misses = count_ones3(miss_vec);

    // Bonus decision uses the combo as it stood before this cycle's events.
    always_comb begin
        points     = (combo_reg >= COMBO_BONUS_AT) ? {COIN_POINTS, 1'b0} : {1'b0, COIN_POINTS};
        add        = 7'(hits) * 7'(points);
        score_sum  = {1'b0, score_reg} + 17'(add);
        score_next = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[15:0];
        combo_sum  = (misses != 2'd0) ? 5'(hits) : ({1'b0, combo_reg} + 5'(hits));
        combo_next = (combo_sum > 5'd15) ? 4'd15 : combo_sum[3:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_reg   <= '0;
            combo_reg   <= '0;
            collect_reg <= 1'b0;
            miss_reg    <= 1'b0;
        end else begin
            score_reg   <= score_next;
            combo_reg   <= combo_next;
            collect_reg <= (hits != 2'd0);
            miss_reg    <= (misses != 2'd0);
        end
    end

    assign score   = score_reg;
    assign combo   = combo_reg;
    assign collect = collect_reg;
    assign miss    = miss_reg;

endmodule

// File: tb/tb_coin_collector.sv
// Directed test of coin_collector: reset, collect, miss, combo bonus,
// simultaneous events, mid-handshake reset and score saturation.
module tb_coin_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  coins;
    logic [26:0] y;
    logic [1:0]  player_lane;
    logic [2:0]  clear_req;
    logic        collect;
    logic        miss;
    logic [15:0] score;
    logic [3:0]  combo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    coin_collector dut (
        .clk         (clk),
        .rst         (rst),
        .coins       (coins),
        .y           (y),
        .player_lane (player_lane),
        .clear_req   (clear_req),
        .collect     (collect),
        .miss        (miss),
        .score       (score),
        .combo       (combo)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [1:0] lane, input logic [8:0] yv);
        coins[2*i +: 2] = lane;
        y[9*i +: 9]     = yv;
    endtask

    // One full occupancy per selected slot: arm, enter window, release.
    task automatic do_hit(input logic [2:0] mask);
        player_lane = 2'd1;
        for (int i = 0; i < 3; i++) if (mask[i]) set_slot(i, 2'd1, 9'd0);
        tick();
        for (int i = 0; i < 3; i++) if (mask[i]) set_slot(i, 2'd1, 9'd400);
        tick();
        for (int i = 0; i < 3; i++) if (mask[i]) set_slot(i, 2'd0, 9'd0);
        tick();
    endtask

    task automatic do_reset();
        coins = '0;
        y     = '0;
        rst   = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int ncol;
        int nmiss;

        // Reset with random inputs
        rst         = 1'b0;
        coins       = 6'($urandom);
        y           = 27'($urandom);
        player_lane = 2'($urandom);
        tick();
        tick();
        check_eq("rst_clear_req", 32'(clear_req), 0);
        check_eq("rst_collect", 32'(collect), 0);
        check_eq("rst_miss", 32'(miss), 0);
        check_eq("rst_score", 32'(score), 0);
        check_eq("rst_combo", 32'(combo), 0);
        coins = '0;
        y     = '0;
        rst   = 1'b1;
        ncol  = 0;
        nmiss = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ncol  += int'(collect);
            nmiss += int'(miss);
        end
        check_eq("idle_no_collect", 32'(ncol), 0);
        check_eq("idle_no_miss", 32'(nmiss), 0);

        // Single collect
        player_lane = 2'd2;
        ncol = 0;
        for (int yy = 0; yy <= 420; yy += 20) begin
            set_slot(0, 2'd2, 9'(yy));
            tick();
            ncol += int'(collect);
            if (yy == 400) begin
                check_eq("single_collect", 32'(collect), 1);
                check_eq("single_score", 32'(score), 1);
                check_eq("single_combo", 32'(combo), 1);
                check_eq("single_clear_req", 32'(clear_req), 1);
            end
        end
        check_eq("single_collect_count", 32'(ncol), 1);
        check_eq("single_hold_clear_req", 32'(clear_req), 1);
        set_slot(0, 2'd0, 9'd0);
        tick();
        check_eq("single_release", 32'(clear_req), 0);

        // Miss
        player_lane = 2'd1;
        nmiss = 0;
        for (int yy = 0; yy <= 440; yy += 40) begin
            set_slot(1, 2'd3, 9'(yy));
            tick();
            nmiss += int'(miss);
        end
        check_eq("miss_none_in_window", 32'(nmiss), 0);
        set_slot(1, 2'd3, 9'd441);
        tick();
        check_eq("miss_pulse", 32'(miss), 1);
        check_eq("miss_combo", 32'(combo), 0);
        check_eq("miss_clear_req", 32'(clear_req), 0);
        check_eq("miss_score", 32'(score), 1);
        set_slot(1, 2'd0, 9'd0);
        tick();
        check_eq("miss_pulse_gone", 32'(miss), 0);

        // Combo bonus from a fresh state
        do_reset();
        for (int i = 0; i < 5; i++) do_hit(3'b001);
        check_eq("combo5_score", 32'(score), 5);
        check_eq("combo5_combo", 32'(combo), 5);
        set_slot(0, 2'd1, 9'd0);
        tick();
        set_slot(0, 2'd1, 9'd420);
        tick();
        check_eq("bonus_score", 32'(score), 7);
        check_eq("bonus_combo", 32'(combo), 6);
        check_eq("bonus_clear_req", 32'(clear_req), 1);

        // Reset mid-handshake drops clear_req without a clock edge
        rst = 1'b0;
        #1;
        check_eq("midrst_clear_req", 32'(clear_req), 0);
        check_eq("midrst_score", 32'(score), 0);
        check_eq("midrst_combo", 32'(combo), 0);
        coins = '0;
        y     = '0;
        tick();
        rst = 1'b1;

        // Simultaneous hit and miss with combo preloaded to 3
        for (int i = 0; i < 3; i++) do_hit(3'b001);
        check_eq("pre_combo3", 32'(combo), 3);
        player_lane = 2'd1;
        set_slot(0, 2'd1, 9'd300);
        set_slot(2, 2'd2, 9'd300);
        tick();
        set_slot(0, 2'd1, 9'd410);
        set_slot(2, 2'd2, 9'd441);
        tick();
        check_eq("simul_collect", 32'(collect), 1);
        check_eq("simul_miss", 32'(miss), 1);
        check_eq("simul_combo", 32'(combo), 1);
        check_eq("simul_score", 32'(score), 4);
        check_eq("simul_clear_req", 32'(clear_req), 1);
        tick();
        check_eq("reentry_no_collect", 32'(collect), 0);
        check_eq("reentry_no_miss", 32'(miss), 0);
        check_eq("reentry_score", 32'(score), 4);
        coins = '0;
        tick();

        // Saturation: build score up to 9998
        do_reset();
        for (int i = 0; i < 5; i++) do_hit(3'b001);
        for (int i = 0; i < 1664; i++) do_hit(3'b111);
        check_eq("ramp_score", 32'(score), 9989);
        check_eq("ramp_combo_sat", 32'(combo), 15);
        player_lane = 2'd1;
        set_slot(1, 2'd2, 9'd0);
        tick();
        set_slot(1, 2'd2, 9'd441);
        tick();
        check_eq("ramp_miss_combo", 32'(combo), 0);
        set_slot(1, 2'd0, 9'd0);
        tick();
        for (int i = 0; i < 7; i++) do_hit(3'b001);
        check_eq("pre_sat_score", 32'(score), 9998);
        check_eq("pre_sat_combo", 32'(combo), 7);
        do_hit(3'b011);
        check_eq("sat_score", 32'(score), 9999);
        check_eq("sat_combo", 32'(combo), 9);
        do_hit(3'b001);
        check_eq("sat_hold_score", 32'(score), 9999);
        check_eq("sat_hold_combo", 32'(combo), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
